// File: rtl/write_back_arbiter_if.sv
// Request/write-back bundle between three requesters, the arbiter and the
// downstream write-back stage. The arbiter uses the slave side.
interface write_back_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [2:0]          req_valid;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*DATA_W-1:0] req_data;
   logic [2:0]          req_ready;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;
   logic [1:0]          wb_src;
   logic                wb_ready;

   modport master (
      output req_valid, req_addr, req_data, wb_ready,
      input  req_ready, wb_valid, wb_addr, wb_data, wb_src
   );

   modport slave (
      input  req_valid, req_addr, req_data, wb_ready,
      output req_ready, wb_valid, wb_addr, wb_data, wb_src
   );
endinterface

// File: rtl/write_back_arbiter.sv
// Round-robin arbiter sharing one registered write-back port among three
// valid/ready requesters, with flush and downstream back-pressure.
module write_back_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   write_back_arbiter_if.slave  bus
);

   localparam int NUM_REQ = 3;

   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_REQ-1:0][DATA_W-1:0] data_a;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
      assign data_a[g] = bus.req_data[g*DATA_W +: DATA_W];
   end

   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
   logic [DATA_W-1:0] wb_data_q,  wb_data_d;
   logic [1:0]        wb_src_q,   wb_src_d;
   logic [1:0]        last_q,     last_d;

   logic       load, take, gnt_vld;
   logic [1:0] gnt_idx, start, cand;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   function automatic logic [1:0] wrap3(input logic [2:0] x);
      return (x >= 3'd3) ? 2'(x - 3'd3) : x[1:0];
   endfunction

   assign load  = !wb_valid_q || bus.wb_ready;
   assign start = wrap3({1'b0, last_q} + 3'd1);

   // Rotate-priority scan starting just after the last winner.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      cand    = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap3({1'b0, start} + 3'(k));
         if (!gnt_vld && bus.req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // rst_n gates ready so nothing is accepted while reset is held.
   assign take          = rst_n && load && !flush && gnt_vld;
   assign bus.req_ready = take ? 3'(3'b001 << gnt_idx) : 3'b000;

   always_comb begin
      case (gnt_idx)
         2'd1:    begin sel_addr = addr_a[1]; sel_data = data_a[1]; end
         2'd2:    begin sel_addr = addr_a[2]; sel_data = data_a[2]; end
         default: begin sel_addr = addr_a[0]; sel_data = data_a[0]; end
      endcase
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      wb_src_d   = wb_src_q;
      last_d     = last_q;
      if (flush) begin
         wb_valid_d = 1'b0;
         last_d     = 2'd2;
      end else if (take) begin
         wb_valid_d = 1'b1;
         wb_addr_d  = sel_addr;
         wb_data_d  = sel_data;
         wb_src_d   = gnt_idx;
         last_d     = gnt_idx;
      end else if (load) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         wb_src_q   <= 2'd0;
         last_q     <= 2'd2;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         wb_src_q   <= wb_src_d;
         last_q     <= last_d;
      end
   end

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_addr  = wb_addr_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_src   = wb_src_q;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed bench for write_back_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge or shortly after it.
module tb_write_back_arbiter;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_cmp;
   int   n_err;

   write_back_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   write_back_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      bus.req_valid = 3'b111; bus.req_addr = '0; bus.req_data = '0; bus.wb_ready = 1'b1;
      #12;
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.wb_valid); end
      n_cmp++; if (bus.wb_addr !== 4'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", bus.wb_addr); end
      n_cmp++; if (bus.wb_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", bus.wb_data); end
      n_cmp++; if (bus.wb_src !== 2'd0) begin n_err++; $display("FAIL rst_src got %0d want 0", bus.wb_src); end
      n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready got %b want 000", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      set_req(1, 4'h5, 8'hA7);
      bus.req_valid = 3'b010; bus.wb_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready got %b want 010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.wb_valid); end
      n_cmp++; if (bus.wb_addr !== 4'h5) begin n_err++; $display("FAIL single_addr got %h want 5", bus.wb_addr); end
      n_cmp++; if (bus.wb_data !== 8'hA7) begin n_err++; $display("FAIL single_data got %h want a7", bus.wb_data); end
      n_cmp++; if (bus.wb_src !== 2'd1) begin n_err++; $display("FAIL single_src got %0d want 1", bus.wb_src); end
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_src [6];
      logic [7:0] exp_dat [6];
      logic [2:0] exp_rdy [6];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      exp_dat = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
      exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      // A flush cycle restores requester 0 as top priority.
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      set_req(0, 4'h1, 8'h10); set_req(1, 4'h2, 8'h20); set_req(2, 4'h3, 8'h30);
      bus.req_valid = 3'b111; bus.wb_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_cmp++; if (bus.req_ready !== exp_rdy[k]) begin n_err++; $display("FAIL fair_ready[%0d] got %b want %b", k, bus.req_ready, exp_rdy[k]); end
         @(negedge clk);
         if (k == 5) bus.req_valid = 3'b000;
         n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d] got %b want 1", k, bus.wb_valid); end
         n_cmp++; if (bus.wb_src !== exp_src[k]) begin n_err++; $display("FAIL fair_src[%0d] got %0d want %0d", k, bus.wb_src, exp_src[k]); end
         n_cmp++; if (bus.wb_data !== exp_dat[k]) begin n_err++; $display("FAIL fair_data[%0d] got %h want %h", k, bus.wb_data, exp_dat[k]); end
      end
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL fair_drain got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_backpressure_flush();
      @(negedge clk);
      set_req(0, 4'h7, 8'h11); set_req(1, 4'h8, 8'h22); set_req(2, 4'h9, 8'h33);
      bus.req_valid = 3'b001; bus.wb_ready = 1'b0;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL bp_first_ready got %b want 001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b110;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL bp_stall_ready[%0d] got %b want 000", k, bus.req_ready); end
         n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h11 || bus.wb_src !== 2'd0)
            begin n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=11 s=0", k, bus.wb_valid, bus.wb_data, bus.wb_src); end
         @(negedge clk);
      end
      bus.wb_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL bp_release_ready got %b want 010", bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.wb_src !== 2'd1 || bus.wb_data !== 8'h22) begin n_err++; $display("FAIL bp_out got s=%0d d=%h want s=1 d=22", bus.wb_src, bus.wb_data); end
      // Stalled output with a pending request, then flush.
      bus.req_valid = 3'b100; bus.wb_ready = 1'b0; flush = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL flush_ready got %b want 000", bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.wb_valid); end
      flush = 1'b0; bus.wb_ready = 1'b1; bus.req_valid = 3'b101;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL flush_tie got %b want 001", bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.wb_src !== 2'd0 || bus.wb_data !== 8'h11) begin n_err++; $display("FAIL flush_tie_out got s=%0d d=%h want s=0 d=11", bus.wb_src, bus.wb_data); end
      bus.req_valid = 3'b100;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b100) begin n_err++; $display("FAIL flush_r2_ready got %b want 100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      n_cmp++; if (bus.wb_src !== 2'd2 || bus.wb_data !== 8'h33) begin n_err++; $display("FAIL flush_r2_out got s=%0d d=%h want s=2 d=33", bus.wb_src, bus.wb_data); end
      @(negedge clk);
   endtask

   task automatic test_idle_drain();
      @(negedge clk);
      set_req(2, 4'hC, 8'h5A);
      bus.req_valid = 3'b100; bus.wb_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 3'b000;
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_src !== 2'd2 || bus.wb_data !== 8'h5A)
         begin n_err++; $display("FAIL drain_out got v=%b s=%0d d=%h want v=1 s=2 d=5a", bus.wb_valid, bus.wb_src, bus.wb_data); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 0", k, bus.wb_valid); end
         n_cmp++; if (bus.wb_addr !== 4'hC || bus.wb_data !== 8'h5A || bus.wb_src !== 2'd2)
            begin n_err++; $display("FAIL drain_hold[%0d] got a=%h d=%h s=%0d want a=c d=5a s=2", k, bus.wb_addr, bus.wb_data, bus.wb_src); end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      set_req(0, 4'h1, 8'hE0); set_req(1, 4'h2, 8'hE1); set_req(2, 4'h3, 8'hE2);
      bus.req_valid = 3'b111; bus.wb_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got %b want 1", bus.wb_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 8'h00) begin n_err++; $display("FAIL ar_clear got v=%b d=%h want v=0 d=00", bus.wb_valid, bus.wb_data); end
      n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL ar_ready got %b want 000", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b110;
      rst_n = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL ar_first_grant got %b want 010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_src !== 2'd1 || bus.wb_data !== 8'hE1)
         begin n_err++; $display("FAIL ar_first_out got v=%b s=%0d d=%h want v=1 s=1 d=e1", bus.wb_valid, bus.wb_src, bus.wb_data); end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure_flush();
      test_idle_drain();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout compared=%0d want finish before 20000", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/write_back_arbiter.md
Name: write_back_arbiter

Overview:
- Shares one registered write-back port between three requesters using round-robin arbitration and valid/ready handshakes.
- Sits in front of register-file or state write-back logic.
- Replaces a fixed case-select mux feeding an enable-gated register: source selection and enable generation are done here, with fairness and downstream back-pressure.

Parameters:
DATA_W, 8, width of each write data word
ADDR_W, 4, width of each write-back address

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous flush: drop pending output, restart priority
req_valid  input  3  per-requester write request, bit i = requester i
req_addr  input  3*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
req_data  input  3*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
req_ready  output  3  one-hot (or zero) accept, combinational
wb_valid  output  1  write-back output valid
wb_addr  output  ADDR_W  write-back address
wb_data  output  DATA_W  write-back data
wb_src  output  2  index of requester that produced current output (0..2)
wb_ready  input  1  downstream accepts output this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - wb_valid=0, wb_addr=0, wb_data=0, wb_src=0.
  - Priority pointer last_grant=2, so requester 0 has highest priority first.
  - req_ready=0 while rst_n low.
- Load condition: load = !wb_valid || wb_ready (output empty or draining this cycle).
- Grant:
  - When load && !flush && |req_valid, grant the first valid requester scanning last_grant+1, last_grant+2, last_grant+3 (mod 3).
  - req_ready = one-hot grant bit; zero otherwise.
  - req_ready depends combinationally on req_valid, wb_valid, wb_ready and flush.
- Handshake: transfer for requester i occurs when req_valid[i] && req_ready[i]. Requesters hold valid/addr/data stable until accepted.
- Capture:
  - On a transfer, next edge: wb_valid=1, wb_addr/wb_data = granted requester's fields, wb_src=i, last_grant=i.
  - Latency: exactly 1 cycle from acceptance to wb_valid.
- Drain: if load and no request, wb_valid goes 0 next edge; wb_addr/wb_data/wb_src hold their previous values.
- Stall: while wb_valid && !wb_ready, wb_addr/wb_data/wb_src are held stable, req_ready=0 and last_grant is unchanged.
- Back-to-back: with wb_ready=1 continuously, one transfer per cycle, zero bubbles.
- Fairness: with all three valid continuously, grants rotate 0,1,2,0,... A requester waits at most 2 grants.
- Flush:
  - Highest priority over everything.
  - Next edge: wb_valid=0, last_grant=2.
  - req_ready=0 in the flush cycle, so no request is accepted and nothing is lost silently.
  - Flush while stalled discards the held output.
- No address hazard checking: identical addresses from different requesters are serialized in grant order.
- Reset mid-stall or mid-transfer: output cleared immediately; the in-flight request is not accepted.
- Implementation structure:
  - One registered output stage plus the pointer register.
  - Grant logic is a 3-way rotate-priority encoder; output mux is a case on the grant index.

Test Plan:
- Reset then single request: req_valid=3'b010, addr=4'h5, data=8'hA7, wb_ready=1 -> req_ready=3'b010 that cycle; next cycle wb_valid=1, wb_addr=5, wb_data=A7, wb_src=1; following cycle wb_valid=0.
- Fairness: all three valid with data 8'h10/8'h20/8'h30 for 6 cycles, wb_ready=1 -> wb_src sequence 0,1,2,0,1,2 with matching data, wb_valid=1 every cycle after the first.
- Back-pressure: output holding src 0 data 8'h11, wb_ready=0 for 3 cycles while req_valid=3'b110 -> req_ready=0, outputs stable at 8'h11; wb_ready=1 -> req_ready=3'b010, then output src 1.
- Flush while stalled: wb_valid=1, wb_ready=0, flush=1, req_valid=3'b100 -> req_ready=0; next cycle wb_valid=0, next grant goes to requester 2 only after flush deasserts, and requester 0 would win a tie.
- Async reset mid-stream: drop rst_n between clock edges during back-to-back traffic -> wb_valid=0 and req_ready=0 immediately, before the next edge; after release, first grant goes to lowest-index valid requester.
- Idle drain: transfer from requester 2 then no requests -> wb_valid 1 for one cycle, then 0, with wb_addr/wb_data/wb_src still holding requester 2's values.
